// File: rtl/seg_scan_capture.sv
// Recovers a 32-bit hex value from a time-multiplexed 8-digit seven-segment scan.
// Latency: a digit is written STABLE_CYCLES edges after its first registered sample; a frame publishes on the edge that writes its last digit.
// Backpressure: none; the display bus cannot be stalled, so unstable, blank or ghosted samples are dropped.
module seg_scan_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic        E,
    input  logic        F,
    input  logic        G,
    input  logic [7:0]  AN,
    output logic [31:0] value,
    output logic [7:0]  seg_err,
    output logic        frame_valid,
    output logic        timeout,
    output logic [7:0]  digit_seen
);

    // Nine bits so the counter can sit one past STABLE_CYCLES=255 and stop.
    localparam int SCW = 9;
    localparam int TOW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [7:0]     an_q;
    logic [6:0]     seg_q;
    logic [SCW-1:0] stab_cnt;
    logic [31:0]    wval;
    logic [7:0]     werr;
    logic [TOW-1:0] to_cnt;

    logic [6:0]     lit;
    logic [3:0]     dec_nib;
    logic           dec_bad;
    logic [2:0]     dig_idx;
    logic [7:0]     dig_mask;
    logic           accept;
    logic           complete;
    logic           to_hit;
    logic           discard;
    logic [31:0]    wval_nxt;
    logic [7:0]     werr_nxt;
    logic [7:0]     seen_nxt;

    // Register the raw display bus; everything downstream sees only these flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= 8'hFF;
            seg_q <= 7'h7F;
        end else begin
            an_q  <= AN;
            seg_q <= {A, B, C, D, E, F, G};
        end
    end

    // Run length of identical samples; saturates one past the threshold so a
    // steady digit is accepted exactly once per stable interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            stab_cnt <= '0;
        end else if ({AN, A, B, C, D, E, F, G} != {an_q, seg_q}) begin
            stab_cnt <= SCW'(1);
        end else if (stab_cnt <= SCW'(STABLE_CYCLES)) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Segment pattern to nibble; anything outside the hex font is flagged.
    always_comb begin
        lit     = ~seg_q;
        dec_nib = 4'h0;
        dec_bad = 1'b0;
        case (lit)
            7'b1111110: dec_nib = 4'h0;
            7'b0110000: dec_nib = 4'h1;
            7'b1101101: dec_nib = 4'h2;
            7'b1111001: dec_nib = 4'h3;
            7'b0110011: dec_nib = 4'h4;
            7'b1011011: dec_nib = 4'h5;
            7'b1011111: dec_nib = 4'h6;
            7'b1110000: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1111011: dec_nib = 4'h9;
            7'b1110111: dec_nib = 4'hA;
            7'b0011111: dec_nib = 4'hB;
            7'b1001110: dec_nib = 4'hC;
            7'b0111101: dec_nib = 4'hD;
            7'b1001111: dec_nib = 4'hE;
            7'b1000111: dec_nib = 4'hF;
            default:    dec_bad = 1'b1;
        endcase
    end

    // Accept/complete/timeout decisions and next working-buffer contents.
    always_comb begin
        dig_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_q[i]) dig_idx = 3'(i);
        end
        dig_mask = 8'd1 << dig_idx;
        accept   = (stab_cnt == SCW'(STABLE_CYCLES)) && $onehot(~an_q);
        complete = accept && ((digit_seen | dig_mask) == 8'hFF);
        to_hit   = (to_cnt == TOW'(TIMEOUT_CYCLES - 1));
        // Completion outranks an expiring timer on the same edge.
        discard  = to_hit && !complete;

        wval_nxt = wval;
        werr_nxt = discard ? 8'h00 : werr;
        seen_nxt = discard ? 8'h00 : digit_seen;
        if (accept) begin
            wval_nxt[{dig_idx, 2'b00} +: 4] = dec_nib;
            werr_nxt[dig_idx]               = dec_bad;
            seen_nxt                        = seen_nxt | dig_mask;
        end
        if (complete) begin
            seen_nxt = 8'h00;
        end
    end

    // Working buffer: latest capture of each digit wins within a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            wval <= '0;
            werr <= '0;
        end else begin
            wval <= wval_nxt;
            werr <= werr_nxt;
        end
    end

    // Frame bookkeeping, timeout timer and the published double buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_seen  <= '0;
            to_cnt      <= '0;
            value       <= '0;
            seg_err     <= '0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            digit_seen  <= seen_nxt;
            to_cnt      <= (complete || to_hit) ? '0 : to_cnt + 1'b1;
            frame_valid <= complete;
            // Only a genuinely partial frame is reported as discarded.
            timeout     <= discard && (digit_seen != 8'h00);
            if (complete) begin
                value   <= wval_nxt;
                seg_err <= werr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomised and directed bench for seg_scan_capture with a queue-based scoreboard.
// Latency: expected pulses are stamped with the edge they must appear after.
// Backpressure: none; the bench drives the display bus freely.
module tb_seg_scan_capture;

    localparam int S = 4;
    localparam int T = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        A, B, C, D, E, F, G;
    logic [7:0]  AN;
    logic [31:0] value;
    logic [7:0]  seg_err;
    logic        frame_valid;
    logic        timeout;
    logic [7:0]  digit_seen;

    logic [7:0]  an_drv  = 8'hFF;
    logic [6:0]  lit_drv = 7'h00;

    assign AN = an_drv;
    assign {A, B, C, D, E, F, G} = ~lit_drv;

    seg_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .AN(AN),
        .value(value), .seg_err(seg_err), .frame_valid(frame_valid),
        .timeout(timeout), .digit_seen(digit_seen)
    );

    always #5 clk = ~clk;

    // Hex font, a..g with a as MSB, lit = 1.
    logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    typedef struct {
        bit          is_to;
        int          cyc;
        logic [31:0] val;
        logic [7:0]  err;
    } ev_t;
    ev_t evq[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit armed = 0;
    int fv_cnt = 0, to_cnt_seen = 0, pulse_cnt = 0;
    int fv_cyc = 0, to_cyc = 0;

    // Reference model state: run length of identical samples, cycles since the
    // last timer clear, digits seen, working digits, published frame.
    logic [14:0] last;
    bit          have_last;
    int          run, age;
    logic [7:0]  m_seen, m_werr, pub_err;
    logic [3:0]  m_nib [8];
    logic [31:0] pub_val;

    function automatic void dec(input logic [6:0] l, output logic [3:0] n, output bit bad);
        n = 4'h0; bad = 1'b1;
        for (int k = 0; k < 16; k++) if (pat[k] == l) begin n = 4'(k); bad = 1'b0; end
    endfunction

    logic [14:0] key;
    bit          acc, bad;
    int          d;
    logic [3:0]  n;
    logic [31:0] v;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            have_last = 0; run = 0; age = 0;
            m_seen = 0; m_werr = 0; pub_val = 0; pub_err = 0;
            for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
        end else begin
            key = {an_drv, lit_drv};
            acc = have_last && (run == S) && $onehot(~last[14:7]);
            d = 0;
            for (int i = 0; i < 8; i++) if (!last[7+i]) d = i;
            dec(last[6:0], n, bad);
            if (have_last && key == last) begin
                if (run <= S) run++;
            end else begin
                last = key; run = 1; have_last = 1;
            end
            if (acc && ((m_seen | (8'd1 << d)) == 8'hFF)) begin
                m_nib[d] = n; m_werr[d] = bad;
                v = 0;
                for (int i = 0; i < 8; i++) v[i*4 +: 4] = m_nib[i];
                pub_val = v; pub_err = m_werr;
                evq.push_back('{1'b0, cyc, v, m_werr});
                m_seen = 0; age = 0;
            end else begin
                if (age == T - 1) begin
                    age = 0;
                    if (m_seen != 0) evq.push_back('{1'b1, cyc, pub_val, pub_err});
                    m_seen = 0; m_werr = 0;
                end else begin
                    age++;
                end
                if (acc) begin m_nib[d] = n; m_werr[d] = bad; m_seen[d] = 1'b1; end
            end
        end
    end

    // Monitor: live state every cycle, pulses popped from the scoreboard queue.
    ev_t ev;
    always @(negedge clk) begin
        if (armed) begin
            tests++;
            if (digit_seen !== m_seen || value !== pub_val || seg_err !== pub_err) begin
                fails++;
                $display("FAIL state @%0d: seen=%h value=%h err=%h required seen=%h value=%h err=%h",
                         cyc, digit_seen, value, seg_err, m_seen, pub_val, pub_err);
            end
            if (frame_valid || timeout) begin
                tests++; pulse_cnt++;
                if (frame_valid) begin fv_cnt++; fv_cyc = cyc; end
                if (timeout) begin to_cnt_seen++; to_cyc = cyc; end
                if (frame_valid && timeout) begin
                    fails++;
                    $display("FAIL pulse_overlap @%0d: frame_valid=1 timeout=1 required not both", cyc);
                end else if (evq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse @%0d: fv=%b to=%b required none", cyc, frame_valid, timeout);
                end else begin
                    ev = evq.pop_front();
                    if (ev.is_to !== timeout || ev.cyc != cyc || value !== ev.val || seg_err !== ev.err) begin
                        fails++;
                        $display("FAIL pulse @%0d: to=%b value=%h err=%h required to=%b @%0d value=%h err=%h",
                                 cyc, timeout, value, seg_err, ev.is_to, ev.cyc, ev.val, ev.err);
                    end
                end
            end else if (evq.size() != 0 && evq[0].cyc <= cyc) begin
                tests++; fails++;
                ev = evq.pop_front();
                $display("FAIL missed_pulse @%0d: no pulse, required to=%b from edge %0d", cyc, ev.is_to, ev.cyc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] an, input logic [6:0] lit, input int cycles);
        an_drv = an; lit_drv = lit;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic show(input int dg, input int nib, input int cycles);
        drive(~(8'd1 << dg), pat[nib], cycles);
    endtask

    task automatic frame(input logic [31:0] fv, input int cycles);
        for (int i = 0; i < 8; i++) show(i, int'(fv[i*4 +: 4]), cycles);
        drive(8'hFF, 7'h00, 3);
        #1;
    endtask

    // Align to a fresh timer period so a directed frame cannot straddle a timeout.
    task automatic sync_idle;
        int k;
        k = 0;
        an_drv = 8'hFF;
        while (age != 2 && k < 300) begin @(negedge clk); k++; end
        tests++;
        if (k >= 300) begin fails++; $display("FAIL sync_idle: age=%0d required 2", age); end
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int p, k, r, nd, a0, b0;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_value", value, 32'h0);
        check("reset_seg_err", seg_err, 32'h0);
        check("reset_digit_seen", digit_seen, 32'h0);
        check("reset_frame_valid", frame_valid, 32'h0);
        check("reset_timeout", timeout, 32'h0);
        armed = 1;

        // Full frame, digits D,C,B,A,4,3,2,1 on AN0..AN7.
        sync_idle();
        p = fv_cnt;
        frame(32'h1234ABCD, 8);
        check("full_value", value, 32'h1234ABCD);
        check("full_seg_err", seg_err, 32'h0);
        check("full_seen_clear", digit_seen, 32'h0);
        check("full_one_pulse", fv_cnt - p, 1);

        // Glitch reject then proper capture of digit 3.
        sync_idle();
        p = pulse_cnt;
        show(3, 5, 3);
        drive(8'hFF, 7'h00, 5);
        #1;
        check("glitch_reject", digit_seen[3], 1'b0);
        check("glitch_no_pulse", pulse_cnt - p, 0);
        show(3, 5, 6);
        drive(8'hFF, 7'h00, 3);
        #1;
        check("glitch_capture", digit_seen[3], 1'b1);

        // Unrecognised pattern on digit 5.
        sync_idle();
        for (int i = 0; i < 8; i++) begin
            if (i == 5) drive(~(8'd1 << i), 7'b0000001, 8);
            else        show(i, 7, 8);
        end
        drive(8'hFF, 7'h00, 3);
        #1;
        check("bad_value", value, 32'h77077777);
        check("bad_seg_err", seg_err, 32'h20);

        // Ghost and blank scans leave the frame untouched.
        sync_idle();
        show(1, 9, 8);
        p = pulse_cnt;
        drive(8'hFC, pat[8], 20);
        drive(8'hFF, pat[8], 20);
        #1;
        check("ghost_seen", digit_seen, 32'h02);
        check("ghost_no_pulse", pulse_cnt - p, 0);

        // Timeout of a partial frame, measured from the previous completion.
        sync_idle();
        frame(32'hCAFE0123, 6);
        for (int i = 0; i < 4; i++) show(i, i, 6);
        an_drv = 8'hFF;
        p = to_cnt_seen; k = 0;
        while (to_cnt_seen == p && k < 200) begin @(negedge clk); #1; k++; end
        check("timeout_seen", to_cnt_seen - p, 1);
        check("timeout_distance", to_cyc - fv_cyc, T);
        check("timeout_seen_clear", digit_seen, 32'h0);
        check("timeout_value_hold", value, 32'hCAFE0123);

        // Reset in the middle of a frame.
        sync_idle();
        for (int i = 0; i < 5; i++) show(i, i + 1, 6);
        #1;
        check("mid_seen", digit_seen, 32'h1F);
        pulse_reset();
        #1;
        check("mid_rst_value", value, 32'h0);
        check("mid_rst_seen", digit_seen, 32'h0);
        check("mid_rst_pulses", {frame_valid, timeout}, 32'h0);
        p = fv_cnt;
        frame(32'h89ABCDEF, 8);
        check("post_rst_value", value, 32'h89ABCDEF);
        check("post_rst_one_pulse", fv_cnt - p, 1);

        // Randomised traffic; the model judges every cycle.
        nd = 0;
        for (int it = 0; it < 500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                pulse_reset();
            end else if (r < 8) begin
                drive(8'hFF, 7'($urandom_range(0, 127)), $urandom_range(1, 12));
            end else if (r < 13) begin
                a0 = $urandom_range(0, 7);
                b0 = (a0 + 1 + $urandom_range(0, 6)) % 8;
                drive(~((8'd1 << a0) | (8'd1 << b0)), 7'($urandom_range(0, 127)), $urandom_range(1, 10));
            end else if (r < 20) begin
                drive(~(8'd1 << $urandom_range(0, 7)), 7'($urandom_range(0, 127)), $urandom_range(1, 10));
            end else begin
                show(nd, $urandom_range(0, 15), $urandom_range(2, 9));
                nd = (nd + 1) % 8;
            end
        end
        drive(8'hFF, 7'h00, 5);
        #1;
        check("queue_drained", evq.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
